// File: rtl/mmul_host_if.sv
// Host-side sequencer for a byte-serial 2x2 Q8.8 matrix multiplier: ships the integer and fraction
// bytes of A/B, then collects four 32-bit results. Optional watchdog: MMUL_HOST_TIMEOUT_EN.
module mmul_host_if #(
  parameter int unsigned HOLD_MIN = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [63:0]  a_mat,
  input  logic [63:0]  b_mat,
  output logic [7:0]   p11,
  output logic [7:0]   p12,
  output logic [7:0]   p21,
  output logic [7:0]   p22,
  output logic [7:0]   q11,
  output logic [7:0]   q12,
  output logic [7:0]   q21,
  output logic [7:0]   q22,
  output logic         in_rdy1,
  output logic         in_rdy2,
  input  logic         read_in1,
  input  logic         read_in2,
  input  logic [31:0]  res_in,
  input  logic         out_rdy,
  output logic [127:0] c_mat,
  output logic         busy,
  output logic         done,
  output logic         err
);

  localparam logic [2:0] StIdle    = 3'd0;
  localparam logic [2:0] StSendInt = 3'd1;
  localparam logic [2:0] StSendDec = 3'd2;
  localparam logic [2:0] StCollect = 3'd3;
  localparam logic [2:0] StFinish  = 3'd4;

  localparam int unsigned HoldW = (HOLD_MIN > 1) ? $clog2(HOLD_MIN + 1) : 1;

  logic [2:0]       state_q, state_d;
  logic [63:0]      a_q, a_d, b_q, b_d;
  logic [127:0]     c_q, c_d;
  logic [1:0]       idx_q, idx_d;
  logic [HoldW-1:0] hold_q, hold_d;
  logic             out_rdy_q;
  logic             out_rise, hold_met, capture;

  assign out_rise = out_rdy & ~out_rdy_q;
  // True in the cycle that completes HOLD_MIN cycles of in_rdy high.
  assign hold_met = (32'(hold_q) + 32'd1) >= HOLD_MIN;

`ifdef MMUL_HOST_TIMEOUT_EN
  logic [11:0] wdog_q, wdog_d;
  logic        err_q, err_d;
`endif

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    idx_d   = idx_q;
    capture = 1'b0;
`ifdef MMUL_HOST_TIMEOUT_EN
    err_d   = err_q;
`endif
    case (state_q)
      StIdle: begin
        if (start) begin
          a_d     = a_mat;
          b_d     = b_mat;
          c_d     = '0;
          idx_d   = 2'd0;
          state_d = StSendInt;
`ifdef MMUL_HOST_TIMEOUT_EN
          err_d   = 1'b0;
`endif
        end
      end
      StSendInt: if (hold_met && read_in1) state_d = StSendDec;
      StSendDec: if (hold_met && read_in2) state_d = StCollect;
      StCollect: begin
        if (out_rise) begin
          capture = 1'b1;
          unique case (idx_q)
            2'd0: c_d[127:96] = res_in;
            2'd1: c_d[95:64]  = res_in;
            2'd2: c_d[63:32]  = res_in;
            2'd3: c_d[31:0]   = res_in;
            default: ;
          endcase
          idx_d = idx_q + 2'd1;
          if (idx_q == 2'd3) state_d = StFinish;
        end
      end
      StFinish: state_d = StIdle;
      default:  state_d = StIdle;
    endcase

`ifdef MMUL_HOST_TIMEOUT_EN
    if (state_q == StIdle || state_d != state_q || capture) begin
      wdog_d = 12'd0;
    end else begin
      wdog_d = wdog_q + 12'd1;
    end
    // Expiry aborts the transfer without a done pulse.
    if (wdog_q == 12'hFFF) begin
      state_d = StIdle;
      err_d   = 1'b1;
      wdog_d  = 12'd0;
    end
`endif

    if (state_d != state_q) begin
      hold_d = '0;
    end else if (32'(hold_q) < HOLD_MIN) begin
      hold_d = hold_q + HoldW'(1);
    end else begin
      hold_d = hold_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      a_q       <= '0;
      b_q       <= '0;
      c_q       <= '0;
      idx_q     <= 2'd0;
      hold_q    <= '0;
      out_rdy_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      c_q       <= c_d;
      idx_q     <= idx_d;
      hold_q    <= hold_d;
      out_rdy_q <= out_rdy;
    end
  end

`ifdef MMUL_HOST_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wdog_q <= 12'd0;
      err_q  <= 1'b0;
    end else begin
      wdog_q <= wdog_d;
      err_q  <= err_d;
    end
  end
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  // Lanes decode from state only, so they move solely on state entry.
  always_comb begin
    {p11, p12, p21, p22, q11, q12, q21, q22} = '0;
    if (state_q == StSendInt) begin
      {p11, p12, p21, p22} = {a_q[63:56], a_q[47:40], a_q[31:24], a_q[15:8]};
      {q11, q12, q21, q22} = {b_q[63:56], b_q[47:40], b_q[31:24], b_q[15:8]};
    end else if (state_q == StSendDec) begin
      {p11, p12, p21, p22} = {a_q[55:48], a_q[39:32], a_q[23:16], a_q[7:0]};
      {q11, q12, q21, q22} = {b_q[55:48], b_q[39:32], b_q[23:16], b_q[7:0]};
    end
  end

  assign in_rdy1 = (state_q == StSendInt);
  assign in_rdy2 = (state_q == StSendDec);
  assign busy    = (state_q == StSendInt) || (state_q == StSendDec) || (state_q == StCollect);
  assign done    = (state_q == StFinish);
  assign c_mat   = c_q;

endmodule

// File: tb/tb_mmul_host_if.sv
// Directed bench for mmul_host_if: handshake timing, result collection, reset, busy starts.
// Define MMUL_HOST_TIMEOUT_EN to also exercise the watchdog.
module tb_mmul_host_if;

  logic         clk = 1'b0;
  logic         rst, start, read_in1, read_in2, out_rdy;
  logic [63:0]  a_mat, b_mat;
  logic [31:0]  res_in;
  logic [7:0]   p11, p12, p21, p22, q11, q12, q21, q22;
  logic         in_rdy1, in_rdy2, busy, done, err;
  logic [127:0] c_mat;
  logic [31:0]  lanes_p, lanes_q;
  int           n_cmp = 0;
  int           n_fail = 0;

  always #5 clk = ~clk;

  assign lanes_p = {p11, p12, p21, p22};
  assign lanes_q = {q11, q12, q21, q22};

  mmul_host_if #(.HOLD_MIN(2)) dut (
    .clk(clk), .rst(rst), .start(start), .a_mat(a_mat), .b_mat(b_mat),
    .p11(p11), .p12(p12), .p21(p21), .p22(p22), .q11(q11), .q12(q12), .q21(q21), .q22(q22),
    .in_rdy1(in_rdy1), .in_rdy2(in_rdy2), .read_in1(read_in1), .read_in2(read_in2),
    .res_in(res_in), .out_rdy(out_rdy), .c_mat(c_mat), .busy(busy), .done(done), .err(err)
  );

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start(input logic [63:0] a, input logic [63:0] b);
    a_mat = a; b_mat = b; start = 1'b1;
    cyc(1);
    start = 1'b0;
  endtask

  // Called one cycle after acceptance; leaves the DUT in COLLECT.
  task automatic run_send();
    read_in1 = 1'b1; cyc(2); read_in1 = 1'b0;
    read_in2 = 1'b1; cyc(2); read_in2 = 1'b0;
  endtask

  task automatic result(input logic [31:0] v, input int h);
    res_in = v; out_rdy = 1'b1; cyc(h); out_rdy = 1'b0; cyc(1);
  endtask

  // Returns in the done cycle with out_rdy still high.
  task automatic collect4(input logic [127:0] v, input int h);
    result(v[127:96], h); result(v[95:64], h); result(v[63:32], h);
    res_in = v[31:0]; out_rdy = 1'b1; cyc(1);
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 0; read_in1 = 0; read_in2 = 0; out_rdy = 0; res_in = '0;
    a_mat = '0; b_mat = '0;
    cyc(2);
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", done); end
    n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b want 0", err); end
    n_cmp++; if ({in_rdy1, in_rdy2} !== 2'b00) begin
      n_fail++; $display("FAIL reset_rdy got %b want 00", {in_rdy1, in_rdy2}); end
    n_cmp++; if (c_mat !== 128'd0) begin n_fail++; $display("FAIL reset_cmat got %h want 0", c_mat); end
    n_cmp++; if ({lanes_p, lanes_q} !== 64'd0) begin
      n_fail++; $display("FAIL reset_lanes got %h want 0", {lanes_p, lanes_q}); end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    logic [127:0] exp_c = {32'hC0DE0011, 32'hC0DE0012, 32'hC0DE0021, 32'hC0DE0022};
    pulse_start(64'h0100_0000_0000_0100, 64'h0200_0200_0200_0200);
    n_cmp++; if ({busy, in_rdy1, in_rdy2} !== 3'b110) begin
      n_fail++; $display("FAIL basic_int_flags got %b want 110", {busy, in_rdy1, in_rdy2}); end
    n_cmp++; if (lanes_p !== 32'h01000001) begin
      n_fail++; $display("FAIL basic_p_int got %h want 01000001", lanes_p); end
    n_cmp++; if (lanes_q !== 32'h02020202) begin
      n_fail++; $display("FAIL basic_q_int got %h want 02020202", lanes_q); end
    cyc(2);
    n_cmp++; if ({in_rdy1, lanes_p} !== {1'b1, 32'h01000001}) begin
      n_fail++; $display("FAIL basic_int_stable got %b %h want 1 01000001", in_rdy1, lanes_p); end
    read_in1 = 1'b1; cyc(1); read_in1 = 1'b0;
    n_cmp++; if ({in_rdy1, in_rdy2} !== 2'b01) begin
      n_fail++; $display("FAIL basic_dec_flags got %b want 01", {in_rdy1, in_rdy2}); end
    n_cmp++; if ({lanes_p, lanes_q} !== 64'd0) begin
      n_fail++; $display("FAIL basic_dec_lanes got %h want 0", {lanes_p, lanes_q}); end
    cyc(2); read_in2 = 1'b1; cyc(1); read_in2 = 1'b0;
    n_cmp++; if ({busy, in_rdy2} !== 2'b10) begin
      n_fail++; $display("FAIL basic_collect got %b want 10", {busy, in_rdy2}); end
    collect4(exp_c, 1);
    out_rdy = 1'b0;
    n_cmp++; if ({done, busy} !== 2'b10) begin
      n_fail++; $display("FAIL basic_done got %b want 10", {done, busy}); end
    n_cmp++; if (c_mat !== exp_c) begin
      n_fail++; $display("FAIL basic_cmat got %h want %h", c_mat, exp_c); end
    cyc(1);
    n_cmp++; if ({done, c_mat} !== {1'b0, exp_c}) begin
      n_fail++; $display("FAIL basic_after got %b %h want 0 %h", done, c_mat, exp_c); end
  endtask

  task automatic test_hold();
    read_in1 = 1'b1; cyc(1);
    pulse_start(64'h1234_5678_9ABC_DEF0, 64'h0);
    n_cmp++; if (in_rdy1 !== 1'b1) begin n_fail++; $display("FAIL hold_c1 got %b want 1", in_rdy1); end
    cyc(1);
    n_cmp++; if (in_rdy1 !== 1'b1) begin n_fail++; $display("FAIL hold_c2 got %b want 1", in_rdy1); end
    cyc(1);
    n_cmp++; if ({in_rdy1, in_rdy2} !== 2'b01) begin
      n_fail++; $display("FAIL hold_c3 got %b want 01", {in_rdy1, in_rdy2}); end
    read_in1 = 1'b0; read_in2 = 1'b1; cyc(1);
    n_cmp++; if (in_rdy2 !== 1'b1) begin n_fail++; $display("FAIL hold2_c2 got %b want 1", in_rdy2); end
    cyc(1); read_in2 = 1'b0;
    n_cmp++; if (in_rdy2 !== 1'b0) begin n_fail++; $display("FAIL hold2_c3 got %b want 0", in_rdy2); end
    collect4({32'd1, 32'd2, 32'd3, 32'd4}, 1);
    out_rdy = 1'b0;
    n_cmp++; if (done !== 1'b1) begin n_fail++; $display("FAIL hold_done got %b want 1", done); end
    cyc(1);
  endtask

  task automatic test_out_rdy_level();
    logic [127:0] exp_c = {32'h00010000, 32'h00020000, 32'h00030000, 32'h00040000};
    pulse_start(64'h0, 64'h0);
    read_in1 = 1'b1; cyc(2); read_in1 = 1'b0;
    read_in2 = 1'b1; out_rdy = 1'b1; res_in = 32'hDEADBEEF; cyc(2); read_in2 = 1'b0;
    cyc(2); out_rdy = 1'b0; cyc(1);
    collect4(exp_c, 5);
    n_cmp++; if ({done, busy} !== 2'b10) begin
      n_fail++; $display("FAIL level_done got %b want 10", {done, busy}); end
    n_cmp++; if (c_mat !== exp_c) begin
      n_fail++; $display("FAIL level_cmat got %h want %h", c_mat, exp_c); end
    cyc(4); out_rdy = 1'b0;
    n_cmp++; if ({done, busy, c_mat} !== {2'b00, exp_c}) begin
      n_fail++; $display("FAIL level_hold got %b%b %h want 00 %h", done, busy, c_mat, exp_c); end
    cyc(1);
  endtask

  task automatic test_reset_mid();
    logic [127:0] exp_c = {32'hA1, 32'hA2, 32'hA3, 32'hA4};
    pulse_start(64'h1234_5678_9ABC_DEF0, 64'h1111_2222_3333_4444);
    run_send();
    result(32'h5555, 1); result(32'h6666, 1);
    rst = 1'b1; cyc(1);
    n_cmp++; if ({busy, done, err, in_rdy1, in_rdy2} !== 5'b0) begin
      n_fail++; $display("FAIL rstmid_flags got %b want 00000", {busy, done, err, in_rdy1, in_rdy2}); end
    n_cmp++; if ({c_mat, lanes_p, lanes_q} !== 192'd0) begin
      n_fail++; $display("FAIL rstmid_data got %h want 0", {c_mat, lanes_p, lanes_q}); end
    rst = 1'b0;
    pulse_start(64'hAA55_0F0F_C3C3_7E81, 64'h0);
    n_cmp++; if ({busy, in_rdy1, lanes_p} !== {2'b11, 32'hAA0FC37E}) begin
      n_fail++; $display("FAIL rstmid_restart got %b%b %h want 11 aa0fc37e", busy, in_rdy1, lanes_p); end
    run_send();
    collect4(exp_c, 2);
    out_rdy = 1'b0;
    n_cmp++; if ({done, c_mat} !== {1'b1, exp_c}) begin
      n_fail++; $display("FAIL rstmid_done got %b %h want 1 %h", done, c_mat, exp_c); end
    cyc(1);
  endtask

  task automatic test_busy_start();
    logic [127:0] exp_c = {32'hB1, 32'hB2, 32'hB3, 32'hB4};
    pulse_start(64'h1234_5678_9ABC_DEF0, 64'h0);
    a_mat = 64'hAA55_0F0F_C3C3_7E81; start = 1'b1; out_rdy = 1'b1; res_in = 32'hBAD0BAD0;
    cyc(1);
    start = 1'b0; out_rdy = 1'b0;
    n_cmp++; if (lanes_p !== 32'h12569ADE) begin
      n_fail++; $display("FAIL busy_int_lanes got %h want 12569ade", lanes_p); end
    read_in1 = 1'b1; cyc(1); read_in1 = 1'b0;
    n_cmp++; if ({in_rdy2, lanes_p} !== {1'b1, 32'h3478BCF0}) begin
      n_fail++; $display("FAIL busy_dec_lanes got %b %h want 1 3478bcf0", in_rdy2, lanes_p); end
    read_in2 = 1'b1; cyc(2); read_in2 = 1'b0;
    collect4(exp_c, 1);
    out_rdy = 1'b0; start = 1'b1;
    n_cmp++; if ({done, c_mat} !== {1'b1, exp_c}) begin
      n_fail++; $display("FAIL busy_done got %b %h want 1 %h", done, c_mat, exp_c); end
    cyc(1); start = 1'b0;
    n_cmp++; if ({busy, in_rdy1} !== 2'b00) begin
      n_fail++; $display("FAIL done_start_ignored got %b want 00", {busy, in_rdy1}); end
    cyc(1);
    n_cmp++; if ({busy, in_rdy1, c_mat} !== {2'b00, exp_c}) begin
      n_fail++; $display("FAIL done_start_idle got %b%b %h want 00 %h", busy, in_rdy1, c_mat, exp_c);
    end
  endtask

`ifdef MMUL_HOST_TIMEOUT_EN
  task automatic test_timeout();
    int k = 0;
    bit saw_done = 1'b0;
    pulse_start(64'h0, 64'h0);
    read_in1 = 1'b1; cyc(2); read_in1 = 1'b0;
    while (err !== 1'b1 && k < 5000) begin
      cyc(1); k++;
      if (done === 1'b1) saw_done = 1'b1;
    end
    n_cmp++; if (k < 4095 || k > 4097) begin
      n_fail++; $display("FAIL timeout_cycles got %0d want 4095..4097", k); end
    n_cmp++; if ({err, in_rdy2, busy, saw_done} !== 4'b1000) begin
      n_fail++; $display("FAIL timeout_state got %b want 1000", {err, in_rdy2, busy, saw_done}); end
    cyc(3);
    n_cmp++; if (err !== 1'b1) begin n_fail++; $display("FAIL timeout_sticky got %b want 1", err); end
    pulse_start(64'h0, 64'h0);
    n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL timeout_clear got %b want 0", err); end
    rst = 1'b1; cyc(1); rst = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_hold();
    test_out_rdy_level();
    test_reset_mid();
    test_busy_start();
`ifdef MMUL_HOST_TIMEOUT_EN
    test_timeout();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/mmul_host_if.md
MMUL_HOST_IF -- requirements
Module: mmul_host_if

Interface
REQ-001 SHALL provide ports: clk input 1 (clock, rising edge); rst input 1 (reset, asynchronous, active-high).
REQ-002 SHALL provide ports: start input 1 (one-cycle request); a_mat input 64 and b_mat input 64 (2x2 Q8.8 matrices, element 11 in [63:48], 12 in [47:32], 21 in [31:16], 22 in [15:0]).
REQ-003 SHALL provide ports: p11, p12, p21, p22 output 8 each (matrix A byte lanes); q11, q12, q21, q22 output 8 each (matrix B byte lanes); in_rdy1 output 1; in_rdy2 output 1.
REQ-004 SHALL provide ports: read_in1 input 1; read_in2 input 1; res_in input 32 ({int_A, int_B, dec_A, dec_B} from the multiplier); out_rdy input 1.
REQ-005 SHALL provide ports: c_mat output 128 (c11 in [127:96], c12, c21, c22 in [31:0]); busy output 1; done output 1 (one-cycle pulse); err output 1.
REQ-006 SHALL provide parameter: HOLD_MIN, default 2, minimum cycles in_rdy1 and in_rdy2 stay asserted.

Function
REQ-007 SHALL implement the states IDLE, SEND_INT, SEND_DEC, COLLECT and FINISH.
REQ-008 IDLE: start=1 SHALL latch a_mat and b_mat, clear c_mat, set busy=1 and go to SEND_INT on the next edge; start while busy=1 SHALL be ignored.
REQ-009 SEND_INT SHALL drive integer bytes [15:8] of each latched element on the p/q lanes and assert in_rdy1.
REQ-010 SEND_INT SHALL stay until in_rdy1 has been high for at least HOLD_MIN cycles and read_in1=1 is sampled; it then deasserts in_rdy1 and goes to SEND_DEC.
REQ-011 SEND_DEC SHALL drive fraction bytes [7:0] on the same lanes and assert in_rdy2, with the same HOLD_MIN and read_in2 rule, then go to COLLECT.
REQ-012 Lanes SHALL change only on state entry and SHALL be stable while in_rdy1 or in_rdy2 is high.
REQ-013 Acknowledges SHALL be level-sensitive; read_in1 or read_in2 already high on entry SHALL still respect HOLD_MIN.
REQ-014 COLLECT SHALL detect rising edges of out_rdy from a registered copy: on each edge capture res_in into slot idx (0=c11, 1=c12, 2=c21, 3=c22) and increment the 2-bit idx.
REQ-015 A level held high on out_rdy SHALL count once; out_rdy already high when COLLECT is entered SHALL NOT count.
REQ-016 After the 4th capture the block SHALL go to FINISH and pulse done=1 for one cycle with c_mat valid in that cycle; busy SHALL clear in the same cycle; state SHALL return to IDLE.
REQ-017 c_mat SHALL hold its value until the next accepted start.
REQ-018 An out_rdy edge outside COLLECT SHALL be ignored.
REQ-019 start in the same cycle as done SHALL be ignored.
REQ-020 idx SHALL wrap 3->0 only through FINISH.

Reset
REQ-021 rst=1 SHALL force IDLE at any time, including mid-transfer, with p*/q*=0, in_rdy1=0, in_rdy2=0, c_mat=0, busy=0, done=0, err=0, idx=0, edge register=0.
REQ-022 The first start SHALL be accepted on the first edge after rst deasserts.

Configuration
REQ-023 With MMUL_HOST_TIMEOUT_EN defined, a 12-bit watchdog SHALL restart on every state change and every capture.
REQ-024 With MMUL_HOST_TIMEOUT_EN defined, when the watchdog reaches 4095 the block SHALL set err=1 (sticky until next accepted start), drop in_rdy1/in_rdy2, and go to IDLE without done.
REQ-025 Without MMUL_HOST_TIMEOUT_EN defined, the watchdog SHALL be absent, err SHALL be tied 0, and the block SHALL wait indefinitely.

Verification
REQ-026 A=I (0x0100 diagonal), B=0x0200 all; multiplier model acks after 3 cycles -> lanes 0x01/0x00/0x00/0x01 then 0x00 bytes; c_mat captured, done pulses once.
REQ-027 read_in1 held high before start -> in_rdy1 still high for exactly 2 cycles (HOLD_MIN=2) before SEND_DEC.
REQ-028 out_rdy held high for 5 cycles per element, 4 pulses with results 0x00010000, 0x00020000, 0x00030000, 0x00040000 -> c_mat=0x00010000_00020000_00030000_00040000.
REQ-029 rst asserted in COLLECT after 2 captures -> all outputs 0 next cycle; new start completes normally.
REQ-030 start pulsed while busy -> no relatch, the in-flight a_mat is the one transmitted.
REQ-031 With MMUL_HOST_TIMEOUT_EN, read_in2 never asserted -> err=1 after 4095 idle cycles, in_rdy2=0, no done.
